reverse_key_expansion: RTL
==========================

REVERSE_KEY_EXPANSION -- requirements
Module: reverse_key_expansion

Interface
REQ-001 clk  input  1  rising-edge clock; all state updates on posedge clk.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 start  input  1  one-cycle request; sampled only in IDLE.
REQ-004 key_in  input  128  AES-128 round key of round round_in; word0 = [127:96], word3 = [31:0].
REQ-005 round_in  input  4  round number of key_in; legal range 0..10.
REQ-006 out_ready  input  1  consumer accepts key_out when key_valid is high.
REQ-007 key_out  output  128  round key of round round_out.
REQ-008 round_out  output  4  round number of key_out.
REQ-009 key_valid  output  1  key_out/round_out valid; held until accepted.
REQ-010 busy  output  1  high in any state other than IDLE.
REQ-011 done  output  1  one-cycle pulse after the round-0 key is accepted, or after a round_in=0 request.
REQ-012 error  output  1  one-cycle pulse when start carries round_in > 10.

Function
REQ-013 The block SHALL compute successive earlier round keys, from round_in-1 down to 0, one key per accepted transfer.
REQ-014 Inverse step, from key w0..w3 of round r to round r-1: p3 = w3^w2; p2 = w2^w1; p1 = w1^w0; p0 = w0 ^ SubWord(RotWord(p3)) ^ Rcon(r).
REQ-015 RotWord(x) SHALL be {x[23:0], x[31:24]}; Rcon(r) SHALL be the standard AES word {rc(r), 24'h0}, rc(1..10) = 01,02,04,08,10,20,40,80,1b,36.
REQ-016 States SHALL be IDLE, RUN and LAST.
REQ-017 IDLE, on start with 1 <= round_in <= 10: load the working register with key_in and the round counter with round_in; go to RUN.
REQ-018 IDLE, on start with round_in = 0: pulse done at the next edge; no key_valid; remain IDLE.
REQ-019 IDLE, on start with round_in > 10: pulse error at the next edge; no key_valid and no done; remain IDLE.
REQ-020 RUN, when key_valid = 0 or (key_valid & out_ready): register the inverse of the working key into key_out and the working register, set round_out = counter-1 and key_valid = 1, and decrement the counter.
REQ-021 RUN: when the key being produced is round 0, go to LAST.
REQ-022 LAST: hold key_out; on key_valid & out_ready, clear key_valid, pulse done and go to IDLE.
REQ-023 Backpressure: while key_valid = 1 and out_ready = 0, key_out, round_out and the working register SHALL remain stable.
REQ-024 Latency: start sampled at edge E0 gives key round_in-1 valid after E1; with out_ready held high, one new key per cycle; done is high in the cycle after the round-0 key is accepted.
REQ-025 start is ignored while busy = 1; key_in and round_in need only be valid in the start cycle.
REQ-026 key_valid, done and error SHALL never be high in the same cycle.

Reset
REQ-027 reset SHALL force IDLE, and set key_out = 0, round_out = 0, key_valid = 0, busy = 0, done = 0, error = 0, working register = 0 and counter = 0.
REQ-028 reset asserted mid-operation SHALL abort the operation with no done pulse; start in the first cycle after reset deasserts is honoured.

Structure
REQ-029 A shared package SHALL hold the state encoding, the Rcon table (index 1..10), the key-width constant (128) and the maximum round constant (10).
REQ-030 The 32-bit SubWord SHALL be the existing subByte sub-module, instantiated once on RotWord(p3).
REQ-031 The inverse step SHALL be combinational from the working register; the next-state logic and output registers SHALL form a single registered stage.

Verification
REQ-032 Scenario: start, round_in = 10, key_in = d014f9a8c9ee2589e13f0cc8b6630ca6, out_ready = 1 -> first key is round 9 = ac7766f319fadc2128d12941575c006e; round 1 = a0fafe1788542cb123a339392a6c7605; round 0 = 2b7e151628aed2a6abf7158809cf4f3c; done one cycle later; 10 keys total.
REQ-033 Scenario: same run with out_ready toggled pseudo-randomly -> identical key sequence; outputs stable while stalled; no key lost or duplicated.
REQ-034 Scenario: start, round_in = 0 -> done pulse after E1, key_valid never high. Start with round_in = 12 -> error pulse only.
REQ-035 Scenario: reset asserted during round 5 output -> all outputs 0 next cycle and no done; a new start right after reset completes correctly.
REQ-036 Scenario: second start while busy with different key_in -> ignored; original sequence completes unchanged.
REQ-037 Scenario: round-trip check, random key K expanded forward to round 10, then fed in here -> round-0 output equals K for 100 random keys.

Source files
------------

// File: rtl/reverse_key_expansion_pkg.sv
// Shared definitions for the AES-128 reverse key expansion: FSM encoding,
// round constants and the byte substitution table.
package reverse_key_expansion_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_LAST
    } state_t;

    localparam int         KEY_WIDTH = 128;
    localparam logic [3:0] MAX_ROUND = 4'd10;

    // rc(1) sits in the most significant byte, rc(10) in the least.
    localparam logic [79:0] RCON_TABLE = 80'h01_02_04_08_10_20_40_80_1b_36;

    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [31:0] rcon(input logic [3:0] r);
        logic [31:0] w;
        w = '0;
        if (r >= 4'd1 && r <= MAX_ROUND) begin
            w = {RCON_TABLE[8*(10-int'(r)) +: 8], 24'h0};
        end
        return w;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TABLE[8*(255-int'(x)) +: 8];
    endfunction

endpackage

// File: rtl/subByte.sv
// 32-bit AES SubWord: four parallel S-box lookups.
module subByte
    import reverse_key_expansion_pkg::*;
(
    input  logic [31:0] word_in,
    output logic [31:0] word_out
);

    assign word_out[31:24] = sbox(word_in[31:24]);
    assign word_out[23:16] = sbox(word_in[23:16]);
    assign word_out[15:8]  = sbox(word_in[15:8]);
    assign word_out[7:0]   = sbox(word_in[7:0]);

endmodule

// File: rtl/reverse_key_expansion.sv
// Walks an AES-128 round key back towards round 0, handing out one earlier
// round key per accepted valid/ready transfer.
module reverse_key_expansion
    import reverse_key_expansion_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [127:0]         key_in,
    input  logic [3:0]           round_in,
    input  logic                 out_ready,
    output logic [127:0]         key_out,
    output logic [3:0]           round_out,
    output logic                 key_valid,
    output logic                 busy,
    output logic                 done,
    output logic                 error
);

    state_t                 state_q, state_d;
    logic [KEY_WIDTH-1:0]   work_q, work_d;
    logic [KEY_WIDTH-1:0]   key_out_q, key_out_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [3:0]             round_out_q, round_out_d;
    logic                   key_valid_q, key_valid_d;
    logic                   done_q, done_d;
    logic                   error_q, error_d;

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] p0, p1, p2, p3;
    logic [31:0] sub_rot;
    logic [KEY_WIDTH-1:0] inv_key;

    assign w0 = work_q[127:96];
    assign w1 = work_q[95:64];
    assign w2 = work_q[63:32];
    assign w3 = work_q[31:0];

    // Undo the forward schedule: the last three words fall out by XOR, and
    // the first word needs the recovered p3 through RotWord/SubWord/Rcon.
    assign p3 = w3 ^ w2;
    assign p2 = w2 ^ w1;
    assign p1 = w1 ^ w0;

    subByte u_sub_byte (
        .word_in  ({p3[23:0], p3[31:24]}),
        .word_out (sub_rot)
    );

    assign p0      = w0 ^ sub_rot ^ rcon(cnt_q);
    assign inv_key = {p0, p1, p2, p3};

    always_comb begin
        state_d     = state_q;
        work_d      = work_q;
        key_out_d   = key_out_q;
        cnt_d       = cnt_q;
        round_out_d = round_out_q;
        key_valid_d = key_valid_q;
        done_d      = 1'b0;
        error_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (round_in == 4'd0) begin
                        done_d = 1'b1;
                    end else if (round_in > MAX_ROUND) begin
                        error_d = 1'b1;
                    end else begin
                        work_d  = key_in;
                        cnt_d   = round_in;
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                // A pending key that is not yet accepted freezes everything.
                if (!key_valid_q || out_ready) begin
                    work_d      = inv_key;
                    key_out_d   = inv_key;
                    round_out_d = cnt_q - 4'd1;
                    key_valid_d = 1'b1;
                    cnt_d       = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = ST_LAST;
                    end
                end
            end
            ST_LAST: begin
                if (key_valid_q && out_ready) begin
                    key_valid_d = 1'b0;
                    done_d      = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            work_q      <= '0;
            key_out_q   <= '0;
            cnt_q       <= '0;
            round_out_q <= '0;
            key_valid_q <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            key_out_q   <= key_out_d;
            cnt_q       <= cnt_d;
            round_out_q <= round_out_d;
            key_valid_q <= key_valid_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign key_out   = key_out_q;
    assign round_out = round_out_q;
    assign key_valid = key_valid_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign error     = error_q;

endmodule
